v810_bus_decode: RTL

Parametrised external-bus address decoder and ready/wait-state generator for the V810 memory interface (`v810_mem` A/MRQn/BCYSTn/READYn/SZRQn side). It replaces hand-wired per-device chip-select and ready logic in machine top levels with NREG address-matched regions. Each region has its own programmable wait states, optional device-ready handshake and 16/32-bit bus sizing. Unmapped accesses terminate by timeout with an error flag.

---
 rtl/v810_bus_decode.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/v810_bus_decode.sv
// v810_bus_decode
//   External-bus address decoder and ready/wait-state generator for the V810
//   memory interface. NREG address-matched regions each get a chip enable,
//   a programmable wait-state count, an optional device-ready handshake and
//   16/32-bit bus sizing. Accesses that match no region, or that stall too
//   long, are force-terminated after TIMEOUT CE cycles with an error pulse.
//
// Ports
//   CLK       system clock
//   RES       synchronous active-high reset
//   CE        clock enable; state advances only when high
//   A         bus address
//   MRQn      memory request, active low
//   BCYSTn    bus cycle start strobe, active low
//   RW        1 = read, 0 = write (captured for error reporting)
//   REG_WAIT  per-region wait-state counts, sampled at cycle start
//   EXT_RDY   per-region device-ready inputs, high = ready
//   CEn       per-region chip enable, active low
//   READYn    bus cycle termination, active low
//   SZRQn     16-bit size request, active low
//   BUS_ERR   one-CE-cycle pulse on timeout termination
//   ERR_ADDR  address of the last timed-out access
//   ERR_RW    RW of the last timed-out access
module v810_bus_decode #(
  parameter int                   NREG       = 4,
  parameter int                   WAIT_W     = 4,
  parameter logic [NREG*32-1:0]   REG_BASE   = {NREG{32'h0}},
  parameter logic [NREG*32-1:0]   REG_MASK   = {NREG{32'h0}},
  parameter logic [NREG-1:0]      REG_16B    = '0,
  parameter logic [NREG-1:0]      REG_EXTRDY = '0,
  parameter int                   TIMEOUT    = 255
) (
  input  logic                     CLK,
  input  logic                     RES,
  input  logic                     CE,
  input  logic [31:0]              A,
  input  logic                     MRQn,
  input  logic                     BCYSTn,
  input  logic                     RW,
  input  logic [NREG*WAIT_W-1:0]   REG_WAIT,
  input  logic [NREG-1:0]          EXT_RDY,
  output logic [NREG-1:0]          CEn,
  output logic                     READYn,
  output logic                     SZRQn,
  output logic                     BUS_ERR,
  output logic [31:0]              ERR_ADDR,
  output logic                     ERR_RW
);

  localparam int         IDX_W   = (NREG > 1) ? $clog2(NREG) : 1;
  localparam logic [7:0] TMO_MAX = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DEVWAIT,
    S_DONE
  } state_t;

  state_t              state;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [7:0]          tmo_cnt;
  logic                hit;
  logic [IDX_W-1:0]    idx;
  logic [31:0]         lat_a;
  logic                lat_rw;

  logic                start;
  logic                dec_hit;
  logic [IDX_W-1:0]    dec_idx;
  logic [WAIT_W-1:0]   dec_wait;
  logic                fin_ok;
  logic                tmo_hit;

  function automatic logic region_hit(input logic [31:0] addr, input int i);
    return (addr & REG_MASK[32*i +: 32]) == (REG_BASE[32*i +: 32] & REG_MASK[32*i +: 32]);
  endfunction

  // Address decode: scan from the top so the lowest matching index wins.
  always_comb begin
    dec_hit = 1'b0;
    dec_idx = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (region_hit(A, i)) begin
        dec_hit = 1'b1;
        dec_idx = IDX_W'(i);
      end
    end
  end

  assign dec_wait = REG_WAIT[dec_idx*WAIT_W +: WAIT_W];
  assign start    = (state == S_IDLE) && !MRQn && !BCYSTn;

  // Normal completion takes priority over a timeout landing on the same cycle.
  always_comb begin
    fin_ok = 1'b0;
    if (state == S_WAIT) begin
      fin_ok = (wait_cnt == WAIT_W'(1)) && !REG_EXTRDY[idx];
    end else if (state == S_DEVWAIT) begin
      fin_ok = hit && EXT_RDY[idx];
    end
  end

  assign tmo_hit = (tmo_cnt + 8'd1) == TMO_MAX;

  // Cycle-start capture of address and direction (data path, no reset).
  always_ff @(posedge CLK) begin
    if (CE && start) begin
      lat_a  <= A;
      lat_rw <= RW;
    end
  end

  // Control FSM with registered bus outputs.
  always_ff @(posedge CLK) begin
    if (RES) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      tmo_cnt  <= '0;
      hit      <= 1'b0;
      idx      <= '0;
      CEn      <= '1;
      READYn   <= 1'b1;
      SZRQn    <= 1'b1;
      BUS_ERR  <= 1'b0;
      ERR_ADDR <= '0;
      ERR_RW   <= 1'b0;
    end else if (CE) begin
      BUS_ERR <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            hit      <= dec_hit;
            idx      <= dec_idx;
            tmo_cnt  <= '0;
            wait_cnt <= dec_hit ? dec_wait : '0;
            if (dec_hit) begin
              CEn   <= ~(NREG'(1) << dec_idx);
              SZRQn <= ~REG_16B[dec_idx];
              // A zero wait count skips WAIT so READYn lands on the first cycle.
              if (dec_wait != '0) begin
                state <= S_WAIT;
              end else if (REG_EXTRDY[dec_idx]) begin
                state <= S_DEVWAIT;
              end else begin
                state  <= S_DONE;
                READYn <= 1'b0;
              end
            end else begin
              state <= S_DEVWAIT;
            end
          end
        end
        S_WAIT, S_DEVWAIT: begin
          tmo_cnt <= tmo_cnt + 8'd1;
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - WAIT_W'(1);
          end
          if (fin_ok) begin
            state  <= S_DONE;
            READYn <= 1'b0;
          end else if (tmo_hit) begin
            state    <= S_DONE;
            READYn   <= 1'b0;
            BUS_ERR  <= 1'b1;
            ERR_ADDR <= lat_a;
            ERR_RW   <= lat_rw;
          end else if (state == S_WAIT && wait_cnt == WAIT_W'(1)) begin
            state <= S_DEVWAIT;
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          READYn <= 1'b1;
          CEn    <= '1;
          SZRQn  <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
